vec_sum: RTL and testbench

- Pipelined population-count block: reports the number of '1' bits in the DATA_W-bit input word `data` on output `sum`.
- The result is reduced modulo 2^POS_W.
- Fixed latency of 3 clock cycles; a new word can be accepted every cycle (fully pipelined, no handshake).
- Used as a datapath helper wherever a bit-count of a status/mask vector is needed.

---
 rtl/vec_sum_if.sv | 15 +
 rtl/vec_sum.sv | 67 ++++++
 tb/tb_vec_sum.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/vec_sum_if.sv
`timescale 1ns/1ps
// vec_sum_if: bundles the datapath signals of the vec_sum popcount block.
//   data : DATA_W-bit word whose set bits are counted (driven by master)
//   sum  : POS_W-bit registered count, modulo 2^POS_W (driven by slave)
// master modport is the producer of words, slave modport is the counter.
interface vec_sum_if #(
  parameter int DATA_W = 16,
  parameter int POS_W  = 4
);
  logic [DATA_W-1:0] data;
  logic [POS_W-1:0]  sum;

  modport master (output data, input sum);
  modport slave  (input data, output sum);
endinterface

// File: rtl/vec_sum.sv
`timescale 1ns/1ps
// vec_sum: three-stage pipelined population count.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears every pipeline register
//   bus   : vec_sum_if slave; bus.data is sampled every edge and
//           bus.sum carries popcount(data) mod 2^POS_W three edges later.
// Stage 1 registers the word, stage 2 registers per-nibble counts,
// stage 3 registers the truncated total. No path from data to sum is
// combinational.
module vec_sum #(
  parameter int DATA_W = 16,
  parameter int POS_W  = 4
) (
  input  logic     clock,
  input  logic     reset,
  vec_sum_if.slave bus
);

  localparam int NIB   = DATA_W / 4;
  // Full-width count so the adder tree never overflows internally.
  localparam int SUM_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]       d_q;
  logic [NIB-1:0][2:0]     nib_cnt;
  logic [NIB-1:0][2:0]     nib_q;
  logic [SUM_W-1:0]        total;
  logic [POS_W-1:0]        sum_q;

  // Stage 1: capture the input word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) d_q <= '0;
    else        d_q <= bus.data;
  end

  // Per-nibble popcount, each in 0..4 so 3 bits suffice.
  always_comb begin
    nib_cnt = '0;
    for (int i = 0; i < NIB; i++) begin
      nib_cnt[i] = 3'(d_q[4*i]) + 3'(d_q[4*i+1]) +
                   3'(d_q[4*i+2]) + 3'(d_q[4*i+3]);
    end
  end

  // Stage 2: register nibble counts.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) nib_q <= '0;
    else        nib_q <= nib_cnt;
  end

  // Sum all nibble counts at full width.
  always_comb begin
    total = '0;
    for (int i = 0; i < NIB; i++) begin
      total = total + SUM_W'(nib_q[i]);
    end
  end

  // Stage 3: the sized cast truncates to POS_W, or zero-extends when
  // POS_W is wider than the exact count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sum_q <= '0;
    else        sum_q <= POS_W'(total);
  end

  assign bus.sum = sum_q;

endmodule

// File: tb/tb_vec_sum.sv
`timescale 1ns/1ps
// tb_vec_sum: self-checking bench for vec_sum. Drives a default 16/4
// instance and an 8/4 instance side by side. Inputs change and outputs
// are sampled on the falling edge. The reference model keeps, per
// instance, a queue of popcounts of words sampled since the last reset
// release; the expected sum is the count sampled three edges back, mod 16.
module tb_vec_sum;

  logic clock;
  logic reset;

  vec_sum_if #(.DATA_W(16), .POS_W(4)) bus ();
  vec_sum_if #(.DATA_W(8),  .POS_W(4)) bus8 ();

  vec_sum #(.DATA_W(16), .POS_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  vec_sum #(.DATA_W(8), .POS_W(4)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared;
  int mismatched;
  int hist[$];
  int hist8[$];

  function automatic int exp_sum();
    if (hist.size() < 3) return 0;
    return hist[hist.size() - 3] % 16;
  endfunction

  function automatic int exp_sum8();
    if (hist8.size() < 3) return 0;
    return hist8[hist8.size() - 3] % 16;
  endfunction

  task automatic check_output(input string tag, input int obs, input int expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: present words at the falling edge, let the rising
  // edge sample them, record them in the model, return at the next fall.
  task automatic apply_stimulus(input logic [15:0] d, input logic [7:0] d8);
    bus.data  = d;
    bus8.data = d8;
    @(posedge clock);
    if (reset) begin
      hist.push_back($countones(d));
      hist8.push_back($countones(d8));
    end
    @(negedge clock);
  endtask

  task automatic check_both(input string tag);
    check_output({tag, "/16"}, int'(bus.sum), exp_sum());
    check_output({tag, "/8"},  int'(bus8.sum), exp_sum8());
  endtask

  // Asynchronous reset pulse between edges; sum must clear at once.
  task automatic reset_pulse(input string tag);
    reset = 1'b0;
    #1;
    check_output({tag, "_async_clr"}, int'(bus.sum), 0);
    hist.delete();
    hist8.delete();
    reset = 1'b1;
  endtask

  logic [15:0] words[$];

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    bus.data   = 16'hFFFF;
    bus8.data  = 8'hFF;

    // Held in reset with all-ones input: sum stays 0.
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(16'hFFFF, 8'hFF);
      check_both("in_reset");
    end

    // Release: 16-bit wraps to 0, 8-bit shows exact 8 on the third edge.
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(16'hFFFF, 8'hFF);
      check_both("release_ones");
    end
    check_output("dw8_exact", int'(bus8.sum), 8);

    // Directed words, each held three edges after a reset pulse.
    words = '{16'b1001101010100011, 16'b0010101111010111,
              16'b1110101010001110, 16'h0000, 16'h0001,
              16'h8000, 16'h7FFF, 16'hFFFF};
    foreach (words[k]) begin
      reset_pulse("directed");
      for (int i = 0; i < 3; i++) begin
        apply_stimulus(words[k], words[k][7:0]);
        check_both("directed");
      end
    end
    check_output("ffff_wrap", int'(bus.sum), 0);

    // Streaming: one new word per cycle, results back to back.
    reset_pulse("stream");
    apply_stimulus(16'h0001, 8'h01);
    check_both("stream");
    apply_stimulus(16'h0003, 8'h03);
    check_both("stream");
    apply_stimulus(16'h0007, 8'h07);
    check_output("stream_first", int'(bus.sum), 1);
    apply_stimulus(16'h000F, 8'h0F);
    check_output("stream_second", int'(bus.sum), 2);
    apply_stimulus(16'h0000, 8'h00);
    check_output("stream_third", int'(bus.sum), 3);
    apply_stimulus(16'h0000, 8'h00);
    check_output("stream_fourth", int'(bus.sum), 4);

    // Randomized stream against the model.
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(16'($urandom), 8'($urandom));
      check_both("random");
    end

    // Mid-pipeline reset: 12 is on sum, 00FF is in flight, reset lands
    // between edges 1 and 2 of the 00FF/0F0F stream.
    reset_pulse("mid_pre");
    apply_stimulus(16'hFFF0, 8'hF0);
    apply_stimulus(16'hFFF0, 8'hF0);
    apply_stimulus(16'h00FF, 8'hFF);
    check_output("mid_before", int'(bus.sum), 12);
    bus.data  = 16'h0F0F;
    bus8.data = 8'h0F;
    reset = 1'b0;
    #1;
    check_output("mid_async_drop", int'(bus.sum), 0);
    hist.delete();
    hist8.delete();
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(16'h0000, 8'h00);
      check_output("mid_after", int'(bus.sum), 0);
      check_output("mid_after8", int'(bus8.sum), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
